mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Multiply/divide unit in the EX stage, beside the ALU, fed the same forwarded operand pair. Executes MIPS mult/multu/div/divu with fixed multi-cycle latency into architectural HI/LO registers. Serves mthi/mtlo/mfhi/mflo. Exports Busy so the hazard unit stalls any later MD instruction at D.

## Interface
- No parameters. Op encodings are fixed values of MDOp, listed under Operation.
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- In0  in  32  operand A (rs): dividend / multiplicand / mthi-mtlo source
- In1  in  32  operand B (rt): divisor / multiplier
- MDOp  in  4  operation select; qualified by Start
- Start  in  1  one-cycle launch strobe from the EX-stage instruction
- Busy  out  1  high while a mult/div is in flight
- HI  out  32  architectural HI register
- LO  out  32  architectural LO register
- Res  out  32  combinational: HI when MDOp=mfhi, LO when MDOp=mflo, else 0

## Operation
- MDOp codes:
  - 0 none
  - 1 mult, 2 multu, 3 div, 4 divu
  - 5 mfhi, 6 mflo, 7 mthi, 8 mtlo
  - 9 madd, 10 maddu, 11 msub, 12 msubu (only with the macro)
  - All other codes behave as none.
- States: IDLE, RUN.
  - Internal 4-bit countdown.
  - HI/LO results are staged in internal regs (tmpHI, tmpLO) computed at launch.
- IDLE, Start=1, op in {mult, multu, div, divu}:
  - Latch the result into tmpHI/tmpLO.
  - Load the count: 5 for mult/multu, 10 for div/divu.
  - Go to RUN.
- IDLE, Start=1, mthi/mtlo: HI<=In0 (resp. LO<=In0) at that edge. No Busy.
- mfhi/mflo: no state change; Res reads current HI/LO.
- RUN:
  - Count decrements each cycle.
  - When the count reaches 1, the next edge commits {HI,LO}<={tmpHI,tmpLO} and returns to IDLE.
- Start while in RUN is ignored, whatever MDOp. The hazard unit guarantees it is never issued.
- Arithmetic:
  - mult: signed 32x32->64, {HI,LO}=product. multu: unsigned.
  - div: LO=quotient truncated toward zero, HI=remainder with the dividend's sign. divu: unsigned.
  - Signed -2^31 / -1: LO=0x80000000, HI=0.
  - Divide by zero (In1=0): on completion HI and LO keep their pre-launch values. Busy still lasts the full 10 cycles.
- Reset:
  - HI=0, LO=0, Busy=0, state IDLE, count 0.
  - Reset mid-operation aborts: the pending result is discarded and never committed.

## Timing
- Start sampled at edge E0. Busy=1 from E0 through E0+N; falls at edge E0+N, where HI/LO update.
- N=5 for mult/multu, N=10 for div/divu.
- mfhi issued in the cycle after Busy falls reads the new value. No HI/LO bypass is provided.
- The hazard unit stalls on (Start | Busy) for any MD op in D, so a back-to-back MD pair is separated by the full latency.
- mthi/mtlo: HI/LO visible the cycle after Start. Busy stays 0.
- Res is purely combinational from MDOp/HI/LO: zero latency, no registered path.

## Configuration
- MDU_MADD_EN defined:
  - Ops 9–12 are legal, latency 5 cycles.
  - madd: {HI,LO}+=signed product. maddu: unsigned. msub/msubu: subtract.
  - The accumulate uses the {HI,LO} captured at launch.
- Undefined:
  - Codes 9–12 behave as none: no Busy, no state change.
  - The accumulate adder is not synthesized.

## Test plan
- Reset, then mult In0=0xFFFFFFFF, In1=2 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same with multu -> HI=0x00000001, LO=0xFFFFFFFE.
- div In0=0xFFFFFFF9 (-7), In1=2 -> Busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu In0=7, In1=2 -> LO=3, HI=1.
- mthi 0x12345678, mtlo 0x9ABCDEF0, then divu by 0 -> after 10 cycles HI=0x12345678, LO=0x9ABCDEF0. div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- mult 3×4 started, reset asserted at cycle 3 -> Busy=0 next edge; HI=LO=0; no later commit.
- Start with MDOp=div during a mult's RUN -> ignored; mult result committed at its 5th cycle. mfhi/mflo on Res match HI/LO with zero delay.
- With MDU_MADD_EN: mtlo 5, mthi 0, then madd 3×4 -> HI=0, LO=0x11. Without the macro: same sequence leaves LO=5 and Busy never rises.

Source files
------------

// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
// Optional accumulate ops (madd/maddu/msub/msubu) are built when MDU_MADD_EN is defined.
//
// state  | meaning
// S_IDLE | no operation in flight; accepts mult/div launch and mthi/mtlo
// S_RUN  | result staged in tmp_hi/tmp_lo, counting down to commit
module mul_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] In0,
  input  logic [31:0] In1,
  input  logic [3:0]  MDOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] Res
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  logic [0:0]  state;
  logic [3:0]  count;
  logic [31:0] tmp_hi, tmp_lo;

  logic        md_go;
  logic [3:0]  md_cnt;
  logic [63:0] md_res;

  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, uq, ur, quo_s, rem_s;

  assign prod_s = {{32{In0[31]}}, In0} * {{32{In1[31]}}, In1};
  assign prod_u = {32'd0, In0} * {32'd0, In1};

  // Signed divide via magnitudes: -2^31 / -1 falls out as 0x80000000 rem 0.
  assign abs_a = In0[31] ? -In0 : In0;
  assign abs_b = In1[31] ? -In1 : In1;
  assign uq    = abs_a / abs_b;
  assign ur    = abs_a % abs_b;
  assign quo_s = (In0[31] ^ In1[31]) ? -uq : uq;
  assign rem_s = In0[31] ? -ur : ur;

  always_comb begin
    md_go  = 1'b0;
    md_cnt = 4'd0;
    md_res = {HI, LO};
    case (MDOp)
      OP_MULT:  begin md_go = 1'b1; md_cnt = 4'd5; md_res = prod_s; end
      OP_MULTU: begin md_go = 1'b1; md_cnt = 4'd5; md_res = prod_u; end
      OP_DIV: begin
        md_go  = 1'b1;
        md_cnt = 4'd10;
        if (In1 != 32'd0) md_res = {rem_s, quo_s};
      end
      OP_DIVU: begin
        md_go  = 1'b1;
        md_cnt = 4'd10;
        if (In1 != 32'd0) md_res = {In0 % In1, In0 / In1};
      end
`ifdef MDU_MADD_EN
      OP_MADD:  begin md_go = 1'b1; md_cnt = 4'd5; md_res = {HI, LO} + prod_s; end
      OP_MADDU: begin md_go = 1'b1; md_cnt = 4'd5; md_res = {HI, LO} + prod_u; end
      OP_MSUB:  begin md_go = 1'b1; md_cnt = 4'd5; md_res = {HI, LO} - prod_s; end
      OP_MSUBU: begin md_go = 1'b1; md_cnt = 4'd5; md_res = {HI, LO} - prod_u; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      count  <= 4'd0;
      HI     <= 32'd0;
      LO     <= 32'd0;
      tmp_hi <= 32'd0;
      tmp_lo <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            if (md_go) begin
              {tmp_hi, tmp_lo} <= md_res;
              count            <= md_cnt;
              state            <= S_RUN;
            end else if (MDOp == OP_MTHI) begin
              HI <= In0;
            end else if (MDOp == OP_MTLO) begin
              LO <= In0;
            end
          end
        end
        S_RUN: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            HI    <= tmp_hi;
            LO    <= tmp_lo;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign Busy = (state == S_RUN);

  always_comb begin
    Res = 32'd0;
    if (MDOp == OP_MFHI) Res = HI;
    else if (MDOp == OP_MFLO) Res = LO;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected HI/LO and latency,
// a monitor pops and compares whenever Busy falls.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] In0, In1;
  logic [3:0]  MDOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI, LO, Res;

  mul_div_unit dut (
    .clk(clk), .reset(reset), .In0(In0), .In1(In1), .MDOp(MDOp),
    .Start(Start), .Busy(Busy), .HI(HI), .LO(LO), .Res(Res)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] mhi = 32'd0, mlo = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit integer arithmetic on the architectural rules.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] hi, inout logic [31:0] lo, output int n);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     acc;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    acc = {hi, lo};
    n = 0;
    case (op)
      4'd1: begin acc = sa * sb; n = 5; end
      4'd2: begin acc = ua * ub; n = 5; end
      4'd3: begin
        n = 10;
        if (b != 0) begin q = sa / sb; r = sa % sb; acc = {r[31:0], q[31:0]}; end
      end
      4'd4: begin
        n = 10;
        if (b != 0) acc = {a % b, a / b};
      end
      4'd7: acc[63:32] = a;
      4'd8: acc[31:0] = a;
`ifdef MDU_MADD_EN
      4'd9:  begin acc = acc + 64'(sa * sb); n = 5; end
      4'd10: begin acc = acc + 64'(ua * ub); n = 5; end
      4'd11: begin acc = acc - 64'(sa * sb); n = 5; end
      4'd12: begin acc = acc - 64'(ua * ub); n = 5; end
`endif
      default: ;
    endcase
    {hi, lo} = acc;
  endtask

  // Monitor: counts Busy cycles and checks each commit against the scoreboard.
  int busy_cnt = 0;
  bit prev_busy = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt  = 0;
      prev_busy = 1'b0;
    end else begin
      if (Busy) busy_cnt++;
      else if (prev_busy) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_commit: got HI=%h LO=%h with no pending op", HI, LO);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("busy_cycles", 64'(busy_cnt), 64'(e.n));
          chk("commit_hi", {32'd0, HI}, {32'd0, e.hi});
          chk("commit_lo", {32'd0, LO}, {32'd0, e.lo});
        end
        busy_cnt = 0;
      end
      prev_busy = Busy;
    end
  end

  task automatic wait_idle(input int limit);
    int k = 0;
    while (Busy && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (Busy) chk("busy_timeout", 64'd1, 64'd0);
  endtask

  task automatic check_res();
    MDOp = 4'd5; #1; chk("res_mfhi", {32'd0, Res}, {32'd0, mhi});
    MDOp = 4'd6; #1; chk("res_mflo", {32'd0, Res}, {32'd0, mlo});
    MDOp = 4'd0; #1; chk("res_none", {32'd0, Res}, 64'd0);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int          n;
    bit          seen;
    logic [31:0] h, l;
    h = mhi;
    l = mlo;
    model(op, a, b, h, l, n);
    if (n > 0) sb_q.push_back('{h, l, n});
    @(negedge clk);
    MDOp = op; In0 = a; In1 = b; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; MDOp = 4'd0;
    mhi = h;
    mlo = l;
    if (n > 0) begin
      chk("busy_rise", {63'd0, Busy}, 64'd1);
      wait_idle(n + 5);
      check_res();
    end else begin
      chk("direct_hi", {32'd0, HI}, {32'd0, mhi});
      chk("direct_lo", {32'd0, LO}, {32'd0, mlo});
      seen = Busy;
      repeat (2) begin @(negedge clk); seen |= Busy; end
      chk("no_busy", {63'd0, seen}, 64'd0);
    end
  endtask

  task automatic chk_hl(input string name, input logic [31:0] eh, input logic [31:0] el);
    chk(name, {HI, LO}, {eh, el});
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; Start = 1'b0; MDOp = 4'd0; In0 = 32'd0; In1 = 32'd0;
    repeat (3) @(negedge clk);
    chk_hl("reset_hilo", 32'd0, 32'd0);
    chk("reset_busy", {63'd0, Busy}, 64'd0);
    reset = 1'b0;
    check_res();

    run_op(4'd1, 32'hFFFF_FFFF, 32'd2);   chk_hl("mult_m1x2", 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op(4'd2, 32'hFFFF_FFFF, 32'd2);   chk_hl("multu_x2", 32'h0000_0001, 32'hFFFF_FFFE);
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2);   chk_hl("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(4'd4, 32'd7, 32'd2);           chk_hl("divu_7_2", 32'd1, 32'd3);
    run_op(4'd7, 32'h1234_5678, 32'd0);
    run_op(4'd8, 32'h9ABC_DEF0, 32'd0);
    run_op(4'd4, 32'd55, 32'd0);          chk_hl("divu_by0", 32'h1234_5678, 32'h9ABC_DEF0);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF); chk_hl("div_ovf", 32'd0, 32'h8000_0000);

    // Reset during a mult: nothing is committed.
    @(negedge clk);
    MDOp = 4'd1; In0 = 32'd3; In1 = 32'd4; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; MDOp = 4'd0;
    @(negedge clk);
    reset = 1'b1;
    sb_q.delete();
    @(negedge clk);
    chk("abort_busy", {63'd0, Busy}, 64'd0);
    chk_hl("abort_hilo", 32'd0, 32'd0);
    reset = 1'b0;
    mhi = 32'd0; mlo = 32'd0;
    repeat (10) @(negedge clk);
    chk_hl("abort_nocommit", 32'd0, 32'd0);

    // Start with div during a mult's RUN is ignored.
    sb_q.push_back('{32'd0, 32'd42, 5});
    @(negedge clk);
    MDOp = 4'd1; In0 = 32'd6; In1 = 32'd7; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; MDOp = 4'd0;
    @(negedge clk);
    MDOp = 4'd3; In0 = 32'd100; In1 = 32'd3; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; MDOp = 4'd0;
    wait_idle(10);
    mhi = 32'd0; mlo = 32'd42;
    chk_hl("ignored_start", 32'd0, 32'd42);
    repeat (3) @(negedge clk);
    chk("ignored_no_busy", {63'd0, Busy}, 64'd0);
    check_res();

    run_op(4'd8, 32'd5, 32'd0);
    run_op(4'd7, 32'd0, 32'd0);
    run_op(4'd9, 32'd3, 32'd4);
`ifdef MDU_MADD_EN
    chk_hl("madd_3x4", 32'd0, 32'h11);
`else
    chk_hl("madd_none", 32'd0, 32'd5);
`endif

    for (int i = 0; i < 60; i++)
      run_op(4'($urandom_range(0, 15)), rnd_val(), rnd_val());

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
